n_bit1x4_demux_router: RTL and testbench

N_BIT1X4_DEMUX_ROUTER -- requirements
Module: n_bit1x4_demux_router

---
 rtl/demux_router_pkg.sv | 33 +++
 rtl/demux_channel_slot.sv | 50 +++++
 rtl/n_bit1x4_demux_router.sv | 83 ++++++++
 tb/tb_n_bit1x4_demux_router.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_router_pkg.sv
// -----------------------------------------------------------------------------
// demux_router_pkg
//   Constants shared by the 1x4 demux router and its channel slots.
//   - sel_e      : destination select codes (SEL_A..SEL_D)
//   - NUM_CH     : number of output channels
//   - CNT_W      : width of the per-channel delivery counters
//   - sel_decode : select code -> one-hot channel vector
// -----------------------------------------------------------------------------
package demux_router_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

    function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] s);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (s)
            SEL_A:   oh = 4'b0001;
            SEL_B:   oh = 4'b0010;
            SEL_C:   oh = 4'b0100;
            default: oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// -----------------------------------------------------------------------------
// demux_channel_slot
//   One output channel of the router: a one-entry holding register with a
//   valid flag and a wrapping count of words delivered to the sink.
//   Ports:
//     gclk, grst_n : clock, async active-low reset
//     wr_en        : router accepted a word for this channel this cycle
//     wr_data      : the accepted word
//     ready        : sink consumes the held word
//     data, valid  : held word and its valid flag
//     cnt          : number of words delivered (wraps at 2**CNT_W)
// -----------------------------------------------------------------------------
module demux_channel_slot
    import demux_router_pkg::*;
#(
    parameter int n = 8
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             wr_en,
    input  logic [n-1:0]     wr_data,
    input  logic             ready,
    output logic [n-1:0]     data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    // READY on an empty slot is ignored.
    assign drain = valid & ready;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            // A write wins over the drain so drain-and-fill keeps valid high.
            if (wr_en) begin
                data  <= wr_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            cnt <= cnt + CNT_W'(drain);
        end
    end

endmodule

// File: rtl/n_bit1x4_demux_router.sv
// -----------------------------------------------------------------------------
// n_bit1x4_demux_router
//   Routes an n-bit word to one of four single-entry output channels chosen
//   by S, with valid/ready handshakes on both sides.
//   Ports:
//     CLK, RST_N            : clock, async active-low reset
//     DIN, S, IN_VALID      : input word, destination select, input valid
//     IN_READY              : router accepts DIN this cycle
//     A..D, A..D_VALID      : channel word and valid
//     A..D_READY            : channel sink consumes the word
//     A..D_CNT              : per-channel delivered-word counters
// -----------------------------------------------------------------------------
module n_bit1x4_demux_router
    import demux_router_pkg::*;
#(
    parameter int n = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [n-1:0]     DIN,
    input  logic [1:0]       S,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [n-1:0]     A,
    output logic [n-1:0]     B,
    output logic [n-1:0]     C,
    output logic [n-1:0]     D,
    output logic             A_VALID,
    output logic             B_VALID,
    output logic             C_VALID,
    output logic             D_VALID,
    input  logic             A_READY,
    input  logic             B_READY,
    input  logic             C_READY,
    input  logic             D_READY,
    output logic [CNT_W-1:0] A_CNT,
    output logic [CNT_W-1:0] B_CNT,
    output logic [CNT_W-1:0] C_CNT,
    output logic [CNT_W-1:0] D_CNT
);

    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_sel;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH-1:0][n-1:0]     ch_data;
    logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;

    assign ch_ready = {D_READY, C_READY, B_READY, A_READY};
    assign ch_sel   = sel_decode(S);

    // Accept when the target slot is empty or is being drained this edge.
    assign IN_READY = ~ch_valid[S] | ch_ready[S];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en[g] = IN_VALID & IN_READY & ch_sel[g];

        demux_channel_slot #(.n(n)) u_slot (
            .gclk    (CLK),
            .grst_n  (RST_N),
            .wr_en   (wr_en[g]),
            .wr_data (DIN),
            .ready   (ch_ready[g]),
            .data    (ch_data[g]),
            .valid   (ch_valid[g]),
            .cnt     (ch_cnt[g])
        );
    end

    assign A       = ch_data[0];
    assign B       = ch_data[1];
    assign C       = ch_data[2];
    assign D       = ch_data[3];
    assign A_VALID = ch_valid[0];
    assign B_VALID = ch_valid[1];
    assign C_VALID = ch_valid[2];
    assign D_VALID = ch_valid[3];
    assign A_CNT   = ch_cnt[0];
    assign B_CNT   = ch_cnt[1];
    assign C_CNT   = ch_cnt[2];
    assign D_CNT   = ch_cnt[3];

endmodule

// File: tb/tb_n_bit1x4_demux_router.sv
// -----------------------------------------------------------------------------
// tb_n_bit1x4_demux_router
//   Directed scenarios for the 1x4 demux router. A behavioural model of the
//   four channels is advanced on every clock edge and compared against the
//   DUT each falling edge; literal expectations pin key points of each
//   scenario.
// -----------------------------------------------------------------------------
module tb_n_bit1x4_demux_router;

    localparam int N = 8;

    logic         CLK;
    logic         RST_N;
    logic [N-1:0] din;
    logic [1:0]   s;
    logic         in_valid;
    logic [3:0]   rdy;

    logic         IN_READY;
    logic [N-1:0] A, B, C, D;
    logic         A_VALID, B_VALID, C_VALID, D_VALID;
    logic [7:0]   A_CNT, B_CNT, C_CNT, D_CNT;

    int errors = 0;
    int checks = 0;

    n_bit1x4_demux_router #(.n(N)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .DIN      (din),
        .S        (s),
        .IN_VALID (in_valid),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .A_VALID  (A_VALID),
        .B_VALID  (B_VALID),
        .C_VALID  (C_VALID),
        .D_VALID  (D_VALID),
        .A_READY  (rdy[0]),
        .B_READY  (rdy[1]),
        .C_READY  (rdy[2]),
        .D_READY  (rdy[3]),
        .A_CNT    (A_CNT),
        .B_CNT    (B_CNT),
        .C_CNT    (C_CNT),
        .D_CNT    (D_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_data  [4];
    bit           m_valid [4];
    logic [7:0]   m_cnt   [4];

    initial begin
        for (int c = 0; c < 4; c++) begin
            m_data[c] = '0; m_valid[c] = 0; m_cnt[c] = '0;
        end
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                for (int c = 0; c < 4; c++) begin
                    m_data[c] = '0; m_valid[c] = 0; m_cnt[c] = '0;
                end
            end else begin
                bit acc;
                acc = in_valid && (!m_valid[s] || rdy[s]);
                for (int c = 0; c < 4; c++) begin
                    if (m_valid[c] && rdy[c]) begin
                        m_cnt[c]   = m_cnt[c] + 8'd1;
                        m_valid[c] = 0;
                    end
                end
                if (acc) begin
                    m_data[s]  = din;
                    m_valid[s] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] d_data  [4];
    logic         d_valid [4];
    logic [7:0]   d_cnt   [4];
    assign d_data[0] = A; assign d_data[1] = B; assign d_data[2] = C; assign d_data[3] = D;
    assign d_valid[0] = A_VALID; assign d_valid[1] = B_VALID;
    assign d_valid[2] = C_VALID; assign d_valid[3] = D_VALID;
    assign d_cnt[0] = A_CNT; assign d_cnt[1] = B_CNT; assign d_cnt[2] = C_CNT; assign d_cnt[3] = D_CNT;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                chk("model_in_ready", 32'(IN_READY), 32'(!m_valid[s] || rdy[s]));
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("model_ch%0d_valid", c), 32'(d_valid[c]), 32'(m_valid[c]));
                    chk($sformatf("model_ch%0d_cnt", c), 32'(d_cnt[c]), 32'(m_cnt[c]));
                    if (m_valid[c])
                        chk($sformatf("model_ch%0d_data", c), 32'(d_data[c]), 32'(m_data[c]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        RST_N    = 1'b0;
        #2;
        RST_N    = 1'b1;
        tick();
    endtask

    task automatic send(input logic [N-1:0] d, input logic [1:0] sel);
        in_valid = 1'b1;
        din      = d;
        s        = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        s        = 2'b00;
        rdy      = 4'hF;
        #3;
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_valids", 32'({A_VALID, B_VALID, C_VALID, D_VALID}), 32'd0);
        chk("rst_cnts", {A_CNT, B_CNT, C_CNT, D_CNT}, 32'd0);
        chk("rst_data", {A, B, C, D}, 32'd0);
        #5;
        RST_N = 1'b1;
        tick();

        // Four words fan out to A..D on consecutive cycles.
        rdy = 4'hF;
        send(8'hAA, 2'b00); tick();
        chk("s1_a", 32'(A), 32'hAA);
        chk("s1_a_valid", 32'(A_VALID), 32'd1);
        send(8'h66, 2'b01); tick();
        chk("s1_b", 32'(B), 32'h66);
        chk("s1_a_cnt", 32'(A_CNT), 32'd1);
        send(8'hDD, 2'b10); tick();
        chk("s1_c", 32'(C), 32'hDD);
        send(8'h11, 2'b11); tick();
        chk("s1_d", 32'(D), 32'h11);
        in_valid = 1'b0; tick();
        chk("s1_cnts", {A_CNT, B_CNT, C_CNT, D_CNT}, 32'h01010101);

        // A stalled: second word must wait, then drain-and-fill.
        do_reset();
        rdy = 4'b1110;
        send(8'hAA, 2'b00); tick();
        send(8'h55, 2'b00); #1;
        chk("s2_stall_ready", 32'(IN_READY), 32'd0);
        tick();
        chk("s2_hold_a", 32'(A), 32'hAA);
        din = 8'h77; tick();          // DIN wiggle while stalled
        chk("s2_hold_a2", 32'(A), 32'hAA);
        din = 8'h55;
        rdy[0] = 1'b1; #1;
        chk("s2_fill_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("s2_a55", 32'(A), 32'h55);
        chk("s2_a_valid", 32'(A_VALID), 32'd1);
        in_valid = 1'b0; tick();
        chk("s2_a_cnt", 32'(A_CNT), 32'd2);

        // A full and stalled does not block B.
        do_reset();
        rdy = 4'b1110;
        send(8'hAA, 2'b00); tick();
        send(8'h66, 2'b01); #1;
        chk("s3_in_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("s3_b_valid", 32'(B_VALID), 32'd1);
        chk("s3_a_held", {24'd0, A}, 32'hAA);
        in_valid = 1'b0; tick();

        // 256 words to D at full rate, counter wraps.
        do_reset();
        rdy = 4'hF;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 2'b11); #1;
            chk($sformatf("s4_ready_%0d", i), 32'(IN_READY), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("s4_cnt_ff", 32'(D_CNT), 32'hFF);
        tick();
        chk("s4_cnt_wrap", 32'(D_CNT), 32'h00);

        // Mid-stream async reset with C holding a word and C_CNT=5.
        do_reset();
        rdy = 4'hF;
        for (int i = 0; i < 6; i++) begin
            send(8'h30 + 8'(i), 2'b10);
            tick();
        end
        rdy[2] = 1'b0;
        in_valid = 1'b0;
        chk("s5_c_cnt5", 32'(C_CNT), 32'd5);
        chk("s5_c_valid", 32'(C_VALID), 32'd1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("s5_rst_c_valid", 32'(C_VALID), 32'd0);
        chk("s5_rst_c_cnt", 32'(C_CNT), 32'd0);
        chk("s5_rst_c", 32'(C), 32'd0);
        #1;
        RST_N = 1'b1;
        tick();
        rdy = 4'hF;
        send(8'h9E, 2'b10); tick();
        chk("s5_after_c", 32'(C), 32'h9E);
        chk("s5_after_cnt", 32'(C_CNT), 32'd0);
        in_valid = 1'b0; tick();

        // Drain-and-fill on B.
        do_reset();
        rdy = 4'hF;
        send(8'h11, 2'b01); tick();
        send(8'h3C, 2'b01); #1;
        chk("s6_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("s6_b", 32'(B), 32'h3C);
        chk("s6_b_valid", 32'(B_VALID), 32'd1);
        chk("s6_b_cnt", 32'(B_CNT), 32'd1);
        in_valid = 1'b0; tick();
        chk("s6_b_cnt2", 32'(B_CNT), 32'd2);

        // READY on an empty channel does nothing.
        tick();
        chk("s7_idle_cnts", {A_CNT, B_CNT, C_CNT, D_CNT}, 32'h00020000);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
